// File: rtl/nbcac_dec_arbiter.sv
// nbcac_dec_arbiter: round-robin arbiter sharing one combinational 11-bit
// NBCAC decoder among NREQ receive channels, with a registered valid/ready
// result slot tagged with the winning requester ID.
// Optional range checking (out_err / err_cnt) is enabled by defining
// NBCAC_DEC_RANGE_CHECK_EN; otherwise those outputs are tied to zero.

module nbcac_11di_decoder_core (
    input  logic [15:0] code,
    output logic [10:0] data
);
    // Weight of codeword bit k (decoder input d[k+1])
    localparam logic [10:0] WEIGHT [16] = '{
        11'd1,   11'd1220, 11'd754, 11'd466, 11'd288, 11'd178, 11'd110, 11'd68,
        11'd42,  11'd26,   11'd16,  11'd10,  11'd6,   11'd4,   11'd2,   11'd2
    };

    // Weighted sum of set codeword bits, modulo 2048
    always_comb begin
        data = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (code[k]) data = data + WEIGHT[k];
        end
    end
endmodule

module nbcac_dec_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [16*NREQ-1:0] req_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [10:0]        out_data,
    output logic [IDW-1:0]     out_id,
    output logic               out_err,
    output logic [7:0]         err_cnt,
    input  logic               err_clr
);
    localparam int unsigned NREQ_U = NREQ;

    logic            out_valid_q, out_valid_d;
    logic [10:0]     out_data_q, out_data_d;
    logic [IDW-1:0]  out_id_q, out_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic            slot_free;
    logic            grant_hit;
    logic [IDW-1:0]  grant;
    logic            accept;
    logic [15:0]     sel_code;
    logic [10:0]     dec_data;
    int unsigned     scan_idx;

    // Round-robin search from the pointer upward, wrapping at NREQ-1
    always_comb begin
        grant     = '0;
        grant_hit = 1'b0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            scan_idx = (32'(ptr_q) + i) % NREQ_U;
            if (!grant_hit && req_valid[scan_idx]) begin
                grant_hit = 1'b1;
                grant     = scan_idx[IDW-1:0];
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    assign accept    = slot_free && grant_hit;
    assign sel_code  = req_code[16*grant +: 16];

    // Only the granted requester sees ready, and only when the slot can load
    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant] = 1'b1;
    end

    nbcac_11di_decoder_core u_core (
        .code (sel_code),
        .data (dec_data)
    );

    // Output slot and pointer next-state: reload on accept, drain otherwise
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = dec_data;
            out_id_d    = grant;
            ptr_d       = (grant == IDW'(NREQ_U - 1)) ? '0 : grant + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Slot and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef NBCAC_DEC_RANGE_CHECK_EN
    localparam logic [11:0] WEIGHT12 [16] = '{
        12'd1,   12'd1220, 12'd754, 12'd466, 12'd288, 12'd178, 12'd110, 12'd68,
        12'd42,  12'd26,   12'd16,  12'd10,  12'd6,   12'd4,   12'd2,   12'd2
    };

    logic [11:0] sum12;
    logic        out_err_q, out_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Untruncated sum of the selected codeword; bit 11 flags overflow past 2047
    always_comb begin
        sum12 = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (sel_code[k]) sum12 = sum12 + WEIGHT12[k];
        end
    end

    // Error flag follows the data slot; counter saturates, clear wins
    always_comb begin
        out_err_d = out_err_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            out_err_d = sum12[11];
            if (sum12[11] && err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
        end
        if (err_clr) err_cnt_d = '0;
    end

    // Error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            out_err_q <= out_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_err = out_err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign out_err        = 1'b0;
    assign err_cnt        = '0;
`endif
endmodule
